serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port start_valid  input  1  the operand pair a/b is offered.
REQ-005 The block SHALL have port start_ready  output  1  the block can accept operands.
REQ-006 The block SHALL have port a  input  WIDTH  the minuend, sampled on acceptance.
REQ-007 The block SHALL have port b  input  WIDTH  the subtrahend, sampled on acceptance.
REQ-008 The block SHALL have port diff  output  WIDTH  the registered result a-b modulo 2^WIDTH.
REQ-009 The block SHALL have port borrow  output  1  the final borrow out, which is 1 iff a<b unsigned.
REQ-010 The block SHALL have port ovf  output  1  the signed (two's complement) overflow flag.
REQ-011 The block SHALL have port done_valid  output  1  diff/borrow/ovf hold a new result.
REQ-012 The block SHALL have port done_ready  input  1  the consumer accepts the result.
REQ-013 The block SHALL have port busy  output  1  high whenever the block is not in IDLE.

Function
REQ-014 The block SHALL implement the FSM states IDLE, RUN and DONE, with state IDLE on reset.
REQ-015 The block SHALL drive start_ready=1 only in IDLE; acceptance SHALL be the rising edge where start_valid and start_ready are both 1.
REQ-016 On acceptance, the block SHALL load a and b into shift registers, clear the internal borrow flop, clear the bit counter and go to RUN.
REQ-017 The block SHALL process exactly one bit per clock in RUN, LSB first, through a full-subtractor cell: d=a^b^bin; bout=(~a&b)|(~(a^b)&bin).
REQ-018 The block SHALL shift each d bit into the result register from the MSB side, so that after WIDTH bits the result is aligned with bit i=d_i.
REQ-019 The block SHALL leave RUN after exactly WIDTH cycles; done_valid SHALL rise WIDTH clocks after the acceptance edge.
REQ-020 On entry to DONE, the block SHALL update diff, borrow and ovf together and drive done_valid=1.
REQ-021 The block SHALL hold DONE, with all outputs stable, until done_valid and done_ready are both 1 at a rising edge, then return to IDLE.
REQ-022 If done_ready is already 1 when DONE is entered, the block SHALL stay in DONE for exactly one cycle; a new start SHALL be accepted at the earliest one cycle later, from IDLE.
REQ-023 The block SHALL ignore start_valid in RUN and DONE; a and b SHALL not be sampled and nothing SHALL be queued.
REQ-024 The block SHALL keep diff, borrow and ovf at the last completed result while in IDLE and RUN; done_valid SHALL be 0 outside DONE.
REQ-025 The block SHALL use a bit counter of width $clog2(WIDTH)+1; the counter SHALL not wrap within one operation.

Reset
REQ-026 While rst_n=0, the block SHALL immediately force state IDLE; diff, borrow, ovf and done_valid to 0; busy to 0; start_ready to 1; and clear the shift registers, borrow flop and counter.
REQ-027 Reset asserted in RUN or DONE SHALL abort the operation; no partial result SHALL appear, and the first cycle after release SHALL be IDLE.

Configuration
REQ-028 The block SHALL compile signed-overflow detection in only when macro SERIAL_SUB_OVF_EN is defined.
REQ-029 With SERIAL_SUB_OVF_EN defined, ovf SHALL be (a[WIDTH-1]!=b[WIDTH-1]) && (diff[WIDTH-1]!=a[WIDTH-1]), using the accepted operands, and SHALL update in DONE.
REQ-030 Without SERIAL_SUB_OVF_EN, ovf SHALL be constant 0, the operand-MSB capture logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-031 The bench SHALL cover: a=0x05, b=0x03 accepted at edge E0 -> done_valid rises at E8, diff=0x02, borrow=0, ovf=0.
REQ-032 The bench SHALL cover: a=0x03, b=0x05 -> diff=0xFE, borrow=1, ovf=0.
REQ-033 The bench SHALL cover: a=0x80, b=0x01 -> diff=0x7F, borrow=0, ovf=1 with the macro and ovf=0 without it.
REQ-034 The bench SHALL cover: done_ready held 0 for 5 cycles in DONE, with start_valid=1 and a/b changed during RUN -> outputs stable, done_valid=1 throughout, the second request not accepted until after the handshake and IDLE.
REQ-035 The bench SHALL cover: rst_n pulsed low at RUN cycle 4 -> outputs 0 at once, IDLE after release, then 0xFF-0xFF gives diff=0x00, borrow=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial a-b, LSB first, valid/ready on both sides.
// Optional signed overflow flag: define SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bin_q, bin_d;
  logic             borrow_q, borrow_d;
  logic             dv_q, dv_d;

`ifdef SERIAL_SUB_OVF_EN
  logic am_q, am_d;
  logic bm_q, bm_d;
  logic ovf_q, ovf_d;
`endif

  logic             a0, b0;
  logic             d_bit, bout;
  logic             last;
  logic [WIDTH-1:0] res_nxt;

  // Full-subtractor cell on the current LSBs
  always_comb begin
    a0      = a_sh_q[0];
    b0      = b_sh_q[0];
    d_bit   = a0 ^ b0 ^ bin_q;
    bout    = (~a0 & b0) | (~(a0 ^ b0) & bin_q);
    res_nxt = {d_bit, res_q[WIDTH-1:1]};
    last    = (cnt_q == CW'(WIDTH - 1));
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    borrow_d = borrow_q;
    dv_d     = dv_q;
`ifdef SERIAL_SUB_OVF_EN
    am_d     = am_q;
    bm_d     = bm_q;
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          bin_d   = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
`ifdef SERIAL_SUB_OVF_EN
          am_d    = a[WIDTH-1];
          bm_d    = b[WIDTH-1];
`endif
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        bin_d  = bout;
        res_d  = res_nxt;
        cnt_d  = cnt_q + CW'(1);
        if (last) begin
          state_d  = DONE;
          diff_d   = res_nxt;
          borrow_d = bout;
          dv_d     = 1'b1;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d    = (am_q != bm_q) &&
                     (d_bit != am_q);
`endif
        end
      end
      DONE: begin
        if (done_ready) begin
          state_d = IDLE;
          dv_d    = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        dv_d    = 1'b0;
      end
    endcase
  end

  // State and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      borrow_q <= 1'b0;
      dv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      borrow_q <= borrow_d;
      dv_q     <= dv_d;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // Operand sign capture and overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      am_q  <= 1'b0;
      bm_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      am_q  <= am_d;
      bm_q  <= bm_d;
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign diff        = diff_q;
  assign borrow      = borrow_q;
  assign done_valid  = dv_q;
  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor, WIDTH=8.
// Vector table, corner sequences, random vs model.
module tb_serial_subtractor;

  localparam int W = 8;

`ifdef SERIAL_SUB_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] diff;
  logic         borrow;
  logic         ovf;
  logic         done_valid;
  logic         done_ready = 1'b0;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .a(a),
    .b(b),
    .diff(diff),
    .borrow(borrow),
    .ovf(ovf),
    .done_valid(done_valid),
    .done_ready(done_ready),
    .busy(busy)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
  } vec_t;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h",
               nm, act, exp);
    end
  endtask

  // Model: plain integer arithmetic
  function automatic vec_t model(
    input logic [W-1:0] x,
    input logic [W-1:0] y);
    vec_t r;
    int sx, sy, sd;
    r.a = x;
    r.b = y;
    r.diff = W'(int'(x) - int'(y));
    r.borrow = (x < y);
    sx = x[W-1] ? int'(x) - 256 : int'(x);
    sy = y[W-1] ? int'(y) - 256 : int'(y);
    sd = sx - sy;
    r.ovf = OVF_ON && (sd > 127 || sd < -128);
    return r;
  endfunction

  // One operation; hold = DONE cycles with
  // done_ready low; junk = poke start during RUN
  task automatic do_op(input vec_t v,
                       input int hold,
                       input bit junk);
    int k;
    logic [W-1:0] sd;
    logic sb, so;
    @(negedge clk);
    check("idle_ready", start_ready, 1);
    a = v.a;
    b = v.b;
    start_valid = 1'b1;
    done_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    if (!junk) start_valid = 1'b0;
    k = 0;
    while (!done_valid && k < 20) begin
      if (k == 3) begin
        check("run_busy", busy, 1);
        check("run_nrdy", start_ready, 0);
      end
      if (junk) begin
        a = W'($urandom);
        b = W'($urandom);
      end
      k++;
      @(negedge clk);
    end
    check("latency", k, W);
    check("diff", diff, v.diff);
    check("borrow", borrow, v.borrow);
    check("ovf", ovf, v.ovf);
    sd = diff;
    sb = borrow;
    so = ovf;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_dv", done_valid, 1);
      check("hold_out", {sd, sb, so},
            {diff, borrow, ovf});
      check("hold_busy", busy, 1);
    end
    done_ready = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    done_ready = 1'b0;
    check("post_dv", done_valid, 0);
    check("post_idle", busy, 0);
    check("post_keep", diff, v.diff);
  endtask

  vec_t tbl[4];

  initial begin
    tbl[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    tbl[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    tbl[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, OVF_ON};
    tbl[3] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};

    #1;
    check("rst_diff", diff, 0);
    check("rst_dv", done_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rdy", start_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) do_op(tbl[i], 0, 1'b0);

    // Stall in DONE with start poked in RUN
    do_op(model(8'h5A, 8'hC3), 5, 1'b1);
    do_op(model(8'h11, 8'h22), 0, 1'b0);

    // Reset in the middle of RUN
    @(negedge clk);
    a = 8'h80;
    b = 8'h01;
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_diff", diff, 0);
    check("mid_rst_brw", borrow, 0);
    check("mid_rst_ovf", ovf, 0);
    check("mid_rst_dv", done_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rdy", start_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_idle", start_ready, 1);
    check("rel_dv", done_valid, 0);
    do_op(model(8'hFF, 8'hFF), 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      do_op(model(W'($urandom), W'($urandom)),
            int'($urandom_range(0, 2)),
            1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
